// File: rtl/axi4_lite_slave_param.sv
// axi4_lite_slave_param: parametrised AXI4-Lite register bank with byte strobes, DECERR/SLVERR responses and optional privileged-only access
module axi4_lite_slave_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH = 4,
  parameter bit PRIV_ONLY = 1'b0
) (
  input  logic                      i_ACLK,
  input  logic                      i_ARESET,
  input  logic                      i_M_AWVALID,
  output logic                      o_S_AWREADY,
  input  logic [ADDR_WIDTH-1:0]     i_M_AWADDR,
  input  logic [2:0]                i_M_AWPROT,
  input  logic                      i_M_WVALID,
  output logic                      o_S_WREADY,
  input  logic [DATA_WIDTH-1:0]     i_M_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   i_M_WSTRB,
  output logic                      o_S_BVALID,
  input  logic                      i_M_BREADY,
  output logic [1:0]                o_S_BRESP,
  input  logic                      i_M_ARVALID,
  output logic                      o_S_ARREADY,
  input  logic [ADDR_WIDTH-1:0]     i_M_ARADDR,
  input  logic [2:0]                i_M_ARPROT,
  output logic                      o_S_RVALID,
  input  logic                      i_M_RREADY,
  output logic [DATA_WIDTH-1:0]     o_S_RDATA,
  output logic [1:0]                o_S_RRESP
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFS = STRB_WIDTH > 1 ? $clog2(STRB_WIDTH) : 0;
  localparam int WW = ADDR_WIDTH - OFS;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [WW-1:0] LAST = WW'(DEPTH - 1);
  function automatic logic [1:0] resp_of(input logic [WW-1:0] w, input logic p);
    return w > LAST ? 2'b11 : (PRIV_ONLY && !p) ? 2'b10 : 2'b00;
  endfunction
  logic run, aw_held, w_held, aw_prot_q, bvalid, rvalid;
  logic aw_ready, w_ready, ar_ready, aw_hs, w_hs, ar_hs, commit, aw_prot;
  logic [WW-1:0] aw_word_q, aw_word, ar_word;
  logic [DATA_WIDTH-1:0] w_data_q, w_data, rdata;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb;
  logic [1:0] bresp, rresp, wresp, rsp;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic unused_ok;
  assign unused_ok = ^{i_M_AWPROT, i_M_ARPROT, i_M_AWADDR, i_M_ARADDR};
  assign aw_ready = run && !aw_held && !bvalid;
  assign w_ready = run && !w_held && !bvalid;
  assign ar_ready = run && !rvalid;
  assign aw_hs = i_M_AWVALID && aw_ready;
  assign w_hs = i_M_WVALID && w_ready;
  assign ar_hs = i_M_ARVALID && ar_ready;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);
  assign aw_word = aw_held ? aw_word_q : i_M_AWADDR[ADDR_WIDTH-1:OFS];
  assign aw_prot = aw_held ? aw_prot_q : i_M_AWPROT[0];
  assign w_data = w_held ? w_data_q : i_M_WDATA;
  assign w_strb = w_held ? w_strb_q : i_M_WSTRB;
  assign wresp = resp_of(aw_word, aw_prot);
  assign ar_word = i_M_ARADDR[ADDR_WIDTH-1:OFS];
  assign rsp = resp_of(ar_word, i_M_ARPROT[0]);
  assign o_S_AWREADY = aw_ready;
  assign o_S_WREADY = w_ready;
  assign o_S_ARREADY = ar_ready;
  assign o_S_BVALID = bvalid;
  assign o_S_BRESP = bresp;
  assign o_S_RVALID = rvalid;
  assign o_S_RDATA = rdata;
  assign o_S_RRESP = rresp;
  always_ff @(posedge i_ACLK) begin
    if (i_ARESET) begin
      run <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      bvalid <= 1'b0;
      bresp <= 2'b00;
      rvalid <= 1'b0;
      rdata <= '0;
      rresp <= 2'b00;
    end else begin
      run <= 1'b1;
      aw_held <= !commit && (aw_held || aw_hs);
      w_held <= !commit && (w_held || w_hs);
      if (aw_hs) begin
        aw_word_q <= i_M_AWADDR[ADDR_WIDTH-1:OFS];
        aw_prot_q <= i_M_AWPROT[0];
      end
      if (w_hs) begin
        w_data_q <= i_M_WDATA;
        w_strb_q <= i_M_WSTRB;
      end
      bvalid <= commit || (bvalid && !i_M_BREADY);
      if (commit) bresp <= wresp;
      rvalid <= ar_hs || (rvalid && !i_M_RREADY);
      if (ar_hs) begin
        rdata <= rsp == 2'b00 ? regs[ar_word[IW-1:0]] : '0;
        rresp <= rsp;
      end
    end
  end
  always_ff @(posedge i_ACLK) begin
    if (i_ARESET) regs <= '0;
    else if (commit && wresp == 2'b00)
      for (int b = 0; b < STRB_WIDTH; b++)
        if (w_strb[b]) regs[aw_word[IW-1:0]][8*b +: 8] <= w_data[8*b +: 8];
  end
endmodule
